// File: rtl/if_fetch_stage.sv
// IF stage: PC register, instruction memory with program-load port, IF/ID pipeline register.
// Fetch is combinational from pc_out; IF/ID loads one edge later; stalls hold state, nothing is dropped.
module if_fetch_stage #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        if_id_flush,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  localparam int          AW    = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam logic [29:0] DEPTH = 30'(IMEM_WORDS);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  logic [31:0] imem [IMEM_WORDS];

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] fetch_word;
  logic [31:0] count_q;
  logic [29:0] fetch_idx;
  logic [29:0] wr_idx;
  logic        fetch_hit;
  logic        wr_hit;
  logic        ifid_load_valid;
  ifid_t       ifid_q;
  ifid_t       ifid_d;
  logic        unused_bits;

  assign fetch_idx   = pc_q[31:2];
  assign wr_idx      = imem_waddr[31:2];
  assign fetch_hit   = (fetch_idx < DEPTH);
  assign wr_hit      = (wr_idx < DEPTH);
  assign unused_bits = ^{imem_waddr[1:0], branch_target[1:0]};

  // Out-of-range fetches read as NOP rather than aliasing into the array.
  assign fetch_word = fetch_hit ? imem[fetch_idx[AW-1:0]] : NOP;

  always_comb begin
    pc_next = pc_q;
    if (pc_src) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (pc_write) begin
      pc_next = pc_q + 32'd4;
    end
  end

  always_comb begin
    ifid_d          = ifid_q;
    ifid_load_valid = 1'b0;
    if (if_id_flush) begin
      ifid_d = '{pc: 32'h0, instr: NOP, valid: 1'b0};
    end else if (ifid_write) begin
      ifid_d          = '{pc: pc_q, instr: fetch_word, valid: 1'b1};
      ifid_load_valid = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '{pc: 32'h0, instr: NOP, valid: 1'b0};
      count_q <= 32'h0;
    end else begin
      pc_q   <= pc_next;
      ifid_q <= ifid_d;
      if (ifid_load_valid) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Program load is independent of reset so images can be written while the core is held.
  always_ff @(posedge clock) begin
    if (imem_we && wr_hit) begin
      imem[wr_idx[AW-1:0]] <= imem_wdata;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_instr = ifid_q.instr;
  assign if_id_valid = ifid_q.valid;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector bench for if_fetch_stage: each record drives one cycle and checks the state after the edge.
module tb_if_fetch_stage;

  logic        clock;
  logic        reset;
  logic        pc_write;
  logic        ifid_write;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        if_id_flush;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc_out;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int vectors;
  int miscompares;

  typedef struct {
    logic        rst;
    logic        pw;
    logic        iw;
    logic        src;
    logic        fl;
    logic        we;
    logic [31:0] tgt;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] epc;
    logic [31:0] eipc;
    logic [31:0] eins;
    logic        evld;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  if_fetch_stage #(.IMEM_WORDS(256), .RESET_PC(32'h0000_0000)) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .if_id_flush   (if_id_flush),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .pc_out        (pc_out),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic pw, input logic iw, input logic src,
                              input logic fl, input logic we, input logic [31:0] tgt,
                              input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] epc,
                              input logic [31:0] eipc, input logic [31:0] eins, input logic evld,
                              input logic [31:0] ecnt);
    vec_t v;
    v.rst = rst; v.pw = pw; v.iw = iw; v.src = src; v.fl = fl; v.we = we;
    v.tgt = tgt; v.wa = wa; v.wd = wd;
    v.epc = epc; v.eipc = eipc; v.eins = eins; v.evld = evld; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    @(negedge clock);
    reset         = v.rst;
    pc_write      = v.pw;
    ifid_write    = v.iw;
    pc_src        = v.src;
    if_id_flush   = v.fl;
    branch_target = v.tgt;
    imem_we       = v.we;
    imem_waddr    = v.wa;
    imem_wdata    = v.wd;
    @(posedge clock);
    #1;
    vectors++;
    if (pc_out !== v.epc) begin
      miscompares++;
      $display("FAIL %s pc_out: got %h want %h", name, pc_out, v.epc);
    end
    if (if_id_pc !== v.eipc) begin
      miscompares++;
      $display("FAIL %s if_id_pc: got %h want %h", name, if_id_pc, v.eipc);
    end
    if (if_id_instr !== v.eins) begin
      miscompares++;
      $display("FAIL %s if_id_instr: got %h want %h", name, if_id_instr, v.eins);
    end
    if (if_id_valid !== v.evld) begin
      miscompares++;
      $display("FAIL %s if_id_valid: got %b want %b", name, if_id_valid, v.evld);
    end
    if (fetch_count !== v.ecnt) begin
      miscompares++;
      $display("FAIL %s fetch_count: got %0d want %0d", name, fetch_count, v.ecnt);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0050_0113;
  localparam logic [31:0] W1  = 32'h0030_0193;
  localparam logic [31:0] W2  = 32'h0031_00B3;
  localparam logic [31:0] W4  = 32'hAAAA_0001;
  localparam logic [31:0] W4N = 32'h1234_5678;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b0;
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    pc_src        = 1'b0;
    if_id_flush   = 1'b0;
    branch_target = 32'h0;
    imem_we       = 1'b0;
    imem_waddr    = 32'h0;
    imem_wdata    = 32'h0;

    //            rst pw iw src fl we  tgt           waddr         wdata         pc            if_id_pc      instr valid count
    // program load under reset, with reset overriding redirect/advance/flush
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 32'h40,       32'h00,       W0,           32'h0,        32'h0,        NOP, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 32'h40,       32'h04,       W1,           32'h0,        32'h0,        NOP, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 32'h0,        32'h0B,       W2,           32'h0,        32'h0,        NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h0C,       NOP,          32'h0,        32'h0,        NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h10,       W4,           32'h0,        32'h0,        NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h400,      32'hDEADBEEF, 32'h0,        32'h0,        NOP, 0, 0));
    // sequential fetch, then two-cycle stall at pc 8
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        32'h0,        W0,  1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h8,        32'h4,        W1,  1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h8,        32'h4,        W1,  1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h8,        32'h4,        W1,  1, 2));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hC,        32'h8,        W2,  1, 3));
    // taken branch to misaligned 6 with flush
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 32'h6,        32'h0,        32'h0,        32'h4,        32'h0,        NOP, 0, 3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h8,        32'h4,        W1,  1, 4));
    // redirect with pc_write=0, out-of-range fetch, flush beats ifid_write=0
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 32'h400,      32'h0,        32'h0,        32'h400,      32'h4,        W1,  1, 4));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h404,      32'h400,      NOP, 1, 5));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        32'h404,      32'h0,        NOP, 0, 5));
    // mid-run reset with a pending redirect; memory must survive
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 32'h40,       32'h0,        32'h0,        32'h0,        32'h0,        NOP, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        32'h0,        W0,  1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h8,        32'h4,        W1,  1, 2));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hC,        32'h8,        W2,  1, 3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h10,       32'hC,        NOP, 1, 4));
    // write and fetch the same word in one cycle, then rewind
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 32'h0,        32'h10,       W4N,          32'h14,       32'h10,       W4,  1, 5));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 32'h10,       32'h0,        32'h0,        32'h10,       32'h10,       W4,  1, 5));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h14,       32'h10,       W4N, 1, 6));
    // PC wraps modulo 2^32
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h10,       W4N, 1, 6));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'hFFFFFFFC, NOP, 1, 7));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // PC held while IF/ID keeps reloading the same word: each reload counts
    for (int k = 0; k < 3; k++) begin
      apply(mk(1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, W0, 1, 32'(8 + k)),
            $sformatf("reload%0d", k));
    end

    // flush together with ifid_write=1: bubble, no count
    apply(mk(1, 1, 1, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, NOP, 0, 32'd10), "flush_vs_write");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
